// File: rtl/ddr5_cmd_pkg.sv
// Shared DDR5 command encodings and the encoder state type for the
// controller-side command path.
package ddr5_cmd_pkg;

    localparam logic [4:0] CMD_MRW = 5'b00101;
    localparam logic [4:0] CMD_WR  = 5'b01101;

    localparam int CA_CANCEL_BIT = 10;
    localparam int CA_BL_BIT     = 5;

    typedef enum logic {
        TYPE_WRITE = 1'b0,
        TYPE_MRW   = 1'b1
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD_1ST = 2'd1,
        ST_CMD_2ND = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

endpackage

// File: rtl/dfi_command_encoder.sv
// Two-cycle DDR5 MRW/WRITE command encoder: drives both command halves onto
// the DFI address/chip-select bus, then holds deselect for a programmable gap.
module dfi_command_encoder
    import ddr5_cmd_pkg::*;
#(
    parameter int NUM_RANK   = 1,
    parameter int GAP_CYCLES = 0,
    parameter int RANK_W     = (NUM_RANK > 1) ? $clog2(NUM_RANK) : 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_cmd,
    input  logic [RANK_W-1:0]   req_rank,
    input  logic [7:0]          req_mr,
    input  logic [7:0]          req_op,
    input  logic [8:0]          req_wr_a1,
    input  logic [13:0]         req_wr_a2,
    input  logic                req_bl_default,
    output logic [13:0]         dfi_address,
    output logic [NUM_RANK-1:0] dfi_cs_n,
    output logic                rank_err
);

    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [13:0]           addr_reg, addr_next;
    logic [NUM_RANK-1:0]   cs_reg, cs_next;
    logic                  err_reg, err_next;
    logic [13:0]           second_reg, second_next;

    logic [13:0]           first_addr;
    logic [13:0]           second_addr;
    logic [NUM_RANK-1:0]   first_cs;
    logic                  rank_bad;
    logic                  accept;

    assign req_ready = (state_reg == ST_IDLE) && i_enable && !i_reset;
    assign accept    = req_valid && req_ready;
    assign rank_bad  = (32'(req_rank) >= NUM_RANK);

    // An out-of-range rank matches no select bit, so every chip select stays high.
    generate
        for (genvar gi = 0; gi < NUM_RANK; gi++) begin : g_cs
            assign first_cs[gi] = (32'(req_rank) != gi);
        end
    endgenerate

    // Both halves are formed at accept time; the second half is latched so
    // later request changes cannot disturb the command in flight.
    always_comb begin
        first_addr  = {req_wr_a1, CMD_WR};
        second_addr = req_wr_a2;
        second_addr[CA_BL_BIT] = req_bl_default;
        if (cmd_type_e'(req_cmd) == TYPE_MRW) begin
            first_addr  = {1'b0, req_mr, CMD_MRW};
            second_addr = {6'b0, req_op};
            second_addr[CA_CANCEL_BIT] = 1'b0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        cs_next     = cs_reg;
        err_next    = err_reg;
        second_next = second_reg;
        if (i_enable) begin
            err_next = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    addr_next = '0;
                    cs_next   = '1;
                    if (accept) begin
                        state_next  = ST_CMD_1ST;
                        addr_next   = first_addr;
                        cs_next     = first_cs;
                        err_next    = rank_bad;
                        second_next = second_addr;
                    end
                end
                ST_CMD_1ST: begin
                    state_next = ST_CMD_2ND;
                    addr_next  = second_reg;
                    cs_next    = '1;
                end
                ST_CMD_2ND: begin
                    addr_next = '0;
                    cs_next   = '1;
                    if (GAP_CYCLES == 0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt_reg == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            cs_reg     <= '1;
            err_reg    <= 1'b0;
            second_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            cs_reg     <= cs_next;
            err_reg    <= err_next;
            second_reg <= second_next;
        end
    end

    assign dfi_address = addr_reg;
    assign dfi_cs_n    = cs_reg;
    assign rank_err    = err_reg;

endmodule

// File: tb/tb_dfi_command_encoder.sv
// Bench for dfi_command_encoder: dut_a (2 ranks, no gap) and dut_b (3 ranks,
// gap of 3) share clock, reset, enable and request fields.
module tb_dfi_command_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        cmd = 1'b0;
    logic [1:0]  rank = '0;
    logic [7:0]  mr = '0;
    logic [7:0]  op = '0;
    logic [8:0]  a1 = '0;
    logic [13:0] a2 = '0;
    logic        bl = 1'b0;

    logic        ready_a, err_a, ready_b, err_b;
    logic [13:0] addr_a, addr_b;
    logic [1:0]  cs_a;
    logic [2:0]  cs_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dfi_command_encoder #(.NUM_RANK(2), .GAP_CYCLES(0)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .req_valid(valid_a), .req_ready(ready_a), .req_cmd(cmd),
        .req_rank(rank[0:0]), .req_mr(mr), .req_op(op),
        .req_wr_a1(a1), .req_wr_a2(a2), .req_bl_default(bl),
        .dfi_address(addr_a), .dfi_cs_n(cs_a), .rank_err(err_a)
    );

    dfi_command_encoder #(.NUM_RANK(3), .GAP_CYCLES(3)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .req_valid(valid_b), .req_ready(ready_b), .req_cmd(cmd),
        .req_rank(rank), .req_mr(mr), .req_op(op),
        .req_wr_a1(a1), .req_wr_a2(a2), .req_bl_default(bl),
        .dfi_address(addr_b), .dfi_cs_n(cs_b), .rank_err(err_b)
    );

    typedef struct {
        logic        cmd;
        logic        rank;
        logic [7:0]  mr;
        logic [7:0]  op;
        logic [8:0]  a1;
        logic [13:0] a2;
        logic        bl;
        logic [13:0] exp_first;
        logic [1:0]  exp_cs;
        logic [13:0] exp_second;
    } vec_t;

    typedef struct packed {
        logic [13:0] addr;
        logic [2:0]  cs;
        logic        err;
    } bus_t;

    localparam bus_t DESEL = '{addr: 14'h0, cs: 3'b111, err: 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string name, input logic [13:0] ea, input logic [1:0] ec, input logic ee);
        check({name, ".addr"}, 32'(addr_a), 32'(ea));
        check({name, ".cs_n"}, 32'(cs_a), 32'(ec));
        check({name, ".err"}, 32'(err_a), 32'(ee));
    endtask

    task automatic check_b(input string name, input bus_t e);
        check({name, ".addr"}, 32'(addr_b), 32'(e.addr));
        check({name, ".cs_n"}, 32'(cs_b), 32'(e.cs));
        check({name, ".err"}, 32'(err_b), 32'(e.err));
    endtask

    // Reference for dut_b: what the bus must show for the first half of a request.
    function automatic bus_t first_of(input logic c, input logic [1:0] r, input logic [7:0] m,
                                      input logic [8:0] w1);
        bus_t b;
        b.addr = c ? 14'((int'(m) << 5) | 5) : 14'((int'(w1) << 5) | 13);
        b.cs   = (r < 3) ? 3'(7 & ~(1 << r)) : 3'b111;
        b.err  = (r >= 3);
        return b;
    endfunction

    function automatic bus_t second_of(input logic c, input logic [7:0] o, input logic [13:0] w2,
                                       input logic b5);
        bus_t b;
        b.addr = c ? 14'(o) : 14'((int'(w2) & ~32'h20) | (int'(b5) << 5));
        b.cs   = 3'b111;
        b.err  = 1'b0;
        return b;
    endfunction

    vec_t vecs[5];
    bus_t q[$];
    bus_t exp_bus;
    int   t1, t2, desel_cnt, txn;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h08, 8'h98, 9'h000, 14'h0000, 1'b0, 14'h0105, 2'b10, 14'h0098};
        vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 9'h1FF, 14'h0000, 1'b1, 14'h3FED, 2'b01, 14'h0020};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 9'h000, 14'h0000, 1'b0, 14'h1FE5, 2'b01, 14'h00FF};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 9'h000, 14'h3FFF, 1'b0, 14'h000D, 2'b10, 14'h3FDF};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 9'h0AA, 14'h1555, 1'b1, 14'h154D, 2'b10, 14'h1575};

        // Reset held with random request activity.
        rst = 1'b1;
        valid_a = 1'b1;
        valid_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd = 1'($urandom); rank = 2'($urandom); mr = 8'($urandom); op = 8'($urandom);
            a1 = 9'($urandom); a2 = 14'($urandom); bl = 1'($urandom);
            step();
            check_a("reset_a", 14'h0, 2'b11, 1'b0);
            check_b("reset_b", DESEL);
            check("reset_ready_a", 32'(ready_a), 32'd0);
            check("reset_ready_b", 32'(ready_b), 32'd0);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst = 1'b0;
        #1;
        check("post_reset_ready_a", 32'(ready_a), 32'd1);
        check("post_reset_ready_b", 32'(ready_b), 32'd1);
        $display("txn reset done");

        // Table-driven single commands on dut_a.
        for (int i = 0; i < 5; i++) begin
            cmd = vecs[i].cmd; rank = {1'b0, vecs[i].rank}; mr = vecs[i].mr; op = vecs[i].op;
            a1 = vecs[i].a1; a2 = vecs[i].a2; bl = vecs[i].bl;
            valid_a = 1'b1;
            #1;
            check("vec_ready", 32'(ready_a), 32'd1);
            step();
            valid_a = 1'b0;
            mr = ~mr; op = ~op; a1 = ~a1; a2 = ~a2; bl = ~bl;
            check_a($sformatf("vec%0d_first", i), vecs[i].exp_first, vecs[i].exp_cs, 1'b0);
            step();
            check_a($sformatf("vec%0d_second", i), vecs[i].exp_second, 2'b11, 1'b0);
            step();
            check_a($sformatf("vec%0d_desel", i), 14'h0, 2'b11, 1'b0);
            check($sformatf("vec%0d_ready_back", i), 32'(ready_a), 32'd1);
            $display("txn vec%0d cmd=%0d first=%h second=%h", i, vecs[i].cmd, vecs[i].exp_first, vecs[i].exp_second);
        end

        // Enable stall during the first half.
        cmd = 1'b1; rank = 2'd0; mr = 8'h08; op = 8'h98;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check_a("stall_first0", 14'h0105, 2'b10, 1'b0);
        en = 1'b0;
        step();
        check_a("stall_first1", 14'h0105, 2'b10, 1'b0);
        check("stall_ready", 32'(ready_a), 32'd0);
        step();
        check_a("stall_first2", 14'h0105, 2'b10, 1'b0);
        en = 1'b1;
        step();
        check_a("stall_second", 14'h0098, 2'b11, 1'b0);
        step();
        check_a("stall_desel", 14'h0, 2'b11, 1'b0);
        $display("txn enable_stall done");

        // Reset asserted while the second half is on the bus.
        cmd = 1'b0; rank = 2'd1; a1 = 9'h1FF; a2 = 14'h0000; bl = 1'b1;
        valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        step();
        check_a("rstmid_second", 14'h0020, 2'b11, 1'b0);
        rst = 1'b1;
        #1;
        check_a("rstmid_desel", 14'h0, 2'b11, 1'b0);
        check("rstmid_ready", 32'(ready_a), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rstmid_ready_after", 32'(ready_a), 32'd1);
        step();
        check_a("rstmid_no_replay", 14'h0, 2'b11, 1'b0);
        $display("txn reset_mid_command done");

        // Back-to-back requests through the gap on dut_b.
        cmd = 1'b1; rank = 2'd0; mr = 8'h08; op = 8'h98;
        exp_bus = first_of(1'b1, 2'd0, 8'h08, 9'h0);
        t1 = -1; t2 = -1; desel_cnt = 0;
        valid_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (addr_b == exp_bus.addr && cs_b == exp_bus.cs) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
            end else if (t1 >= 0 && t2 < 0 && addr_b == 14'h0 && cs_b == 3'b111) begin
                desel_cnt++;
            end
        end
        valid_b = 1'b0;
        check("gap_first_seen", 32'(t1), 32'd0);
        check("gap_first_to_first", 32'(t2 - t1), 32'd6);
        check("gap_desel_cycles", 32'(desel_cnt), 32'd4);
        for (int i = 0; i < 6; i++) step();
        check("gap_drained_ready", 32'(ready_b), 32'd1);
        $display("txn gap t1=%0d t2=%0d desel=%0d", t1, t2, desel_cnt);

        // Out-of-range rank on dut_b.
        cmd = 1'b0; rank = 2'd3; a1 = 9'h055; a2 = 14'h2AAA; bl = 1'b1;
        valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        check_b("oor_first", '{addr: 14'h0AAD, cs: 3'b111, err: 1'b1});
        step();
        check_b("oor_second", '{addr: 14'h2AAA, cs: 3'b111, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            check_b("oor_gap", DESEL);
            check("oor_gap_ready", 32'(ready_b), 32'd0);
        end
        step();
        check_b("oor_idle", DESEL);
        check("oor_ready_back", 32'(ready_b), 32'd1);
        $display("txn out_of_range_rank done");

        // Randomized traffic on dut_b against a queue-based model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        exp_bus = DESEL;
        txn = 0;
        for (int c = 0; c < 600; c++) begin
            en = ($urandom_range(0, 9) != 0);
            rst = ($urandom_range(0, 99) == 0);
            valid_b = 1'($urandom);
            cmd = 1'($urandom); rank = 2'($urandom); mr = 8'($urandom); op = 8'($urandom);
            a1 = 9'($urandom); a2 = 14'($urandom); bl = 1'($urandom);
            if (rst) begin
                q.delete();
                exp_bus = DESEL;
            end
            #1;
            check("rand_ready", 32'(ready_b), 32'(en && !rst && q.size() == 0));
            if (rst) check_b("rand_rst", exp_bus);
            @(posedge clk);
            #1;
            if (!rst && en) begin
                if (q.size() != 0) begin
                    exp_bus = q.pop_front();
                end else if (valid_b) begin
                    exp_bus = first_of(cmd, rank, mr, a1);
                    q.push_back(second_of(cmd, op, a2, bl));
                    for (int g = 0; g < 4; g++) q.push_back(DESEL);
                    txn++;
                    $display("txn rand%0d cmd=%0d rank=%0d first=%h", txn, cmd, rank, exp_bus.addr);
                end else begin
                    exp_bus = DESEL;
                end
            end
            check_b("rand_bus", exp_bus);
        end
        rst = 1'b0;
        valid_b = 1'b0;
        en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dfi_command_encoder.md
# dfi_command_encoder

Controller-side DDR5 command encoder that generates the two-cycle MRW and WRITE commands consumed by the PHY command/address path. It accepts one request at a time over a valid/ready handshake and drives `dfi_address` and `dfi_cs_n` with the first and second command halves. It then enforces a programmable deselect gap before accepting the next request. It sits between the memory-controller scheduler and the frequency-ratio/command-address blocks.

## Interface
- `NUM_RANK`, default 1: number of ranks, which sets the width of `dfi_cs_n`.
- `GAP_CYCLES`, default 0: extra deselect cycles inserted after the mandatory one, before the next command.
- `RANK_W`, derived as `(NUM_RANK>1) ? $clog2(NUM_RANK) : 1`: width of the rank index.
- `i_clock`  in  1  single clock; all logic is on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  global enable; when low, all state and outputs hold.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on an edge where `req_valid && req_ready`. This output is combinational: `(state==IDLE) && i_enable && !i_reset`.
- `req_cmd`  in  1  request type: 1 = MRW, 0 = WRITE.
- `req_rank`  in  RANK_W  target rank index.
- `req_mr`  in  8  MR address (MRW only).
- `req_op`  in  8  MR operand (MRW only).
- `req_wr_a1`  in  9  WRITE first-half address bits, placed on `dfi_address[13:5]`.
- `req_wr_a2`  in  14  WRITE second-half bits.
- `req_bl_default`  in  1  WRITE second-half bit 5: 1 = default burst length, 0 = MR0 burst length.
- `dfi_address`  out  14  registered command bus.
- `dfi_cs_n`  out  NUM_RANK  registered active-low chip selects.
- `rank_err`  out  1  registered one-cycle pulse: the accepted request had `req_rank >= NUM_RANK`.

## Operation
- **States:** IDLE, CMD_1ST (first half on the bus), CMD_2ND (second half on the bus), GAP.
- **IDLE:**
  - Bus shows deselect: `dfi_address` = 0, `dfi_cs_n` = all 1.
  - On accept, register the first half and go to CMD_1ST.
- **MRW first half:** `dfi_address` = {1'b0, req_mr, 5'b00101}.
- **WRITE first half:** `dfi_address` = {req_wr_a1, 5'b01101}.
- **First-half chip select:** `dfi_cs_n[req_rank]` = 0 and all other bits = 1. For an out-of-range rank, all bits = 1 and `rank_err` pulses.
- **CMD_1ST -> CMD_2ND:** register the second half, with `dfi_cs_n` = all 1.
  - MRW second half: `dfi_address` = {6'b0, req_op}. Bit 10 = 0, so the command is never cancelled.
  - WRITE second half: `req_wr_a2` with bit 5 replaced by `req_bl_default`.
- **CMD_2ND -> deselect:** register deselect.
  - If `GAP_CYCLES` = 0, go to IDLE.
  - Otherwise go to GAP and load the counter with `GAP_CYCLES-1`.
- **GAP:** bus stays at deselect. Decrement the counter each enabled cycle; go to IDLE on the edge where the counter = 0.
- **Request latch:** all request fields are captured on accept. Later changes on `req_*` have no effect on the command in flight.
- **Enable low in any state:** state, counter and outputs hold. `req_ready` = 0, and `rank_err` holds 0 once its pulse has been consumed.
- **Reset asserted at any point:** immediate return to IDLE with deselect outputs. A partially issued command is abandoned and nothing is replayed.
- **Counter:** width is `$clog2(GAP_CYCLES+1)`, minimum 1. It never wraps because it is only decremented when nonzero.

## Timing
- **Reset values:** `dfi_address` = 14'h0, `dfi_cs_n` = all 1, `rank_err` = 0, state = IDLE, counter = 0.
- **Latency:** with the accept edge at k:
  - The first half is visible from k to k+1.
  - The second half is visible from k+1 to k+2.
  - Deselect is visible from edge k+2.
- **Throughput:** there are exactly `1+GAP_CYCLES` deselect cycles between a second half and the next first half. With `GAP_CYCLES` = 0, the next accept is earliest at k+3.
- **`rank_err` timing:** the pulse is visible in the same cycle as the offending first half.

## Structure
- **Shared package `ddr5_cmd_pkg`:**
  - `CMD_MRW` = 5'b00101 and `CMD_WR` = 5'b01101.
  - Second-half bit positions: `CA_CANCEL_BIT` = 10 and `CA_BL_BIT` = 5.
  - A `cmd_type_e` enum (MRW, WRITE).
  - An encoder `state_e` enum.
- **Sub-modules:** none. The FSM, request latch and gap counter live in one module.

## Test plan
- **Reset:** hold `i_reset` = 1 with random `req_*` -> `dfi_cs_n` = all 1, `dfi_address` = 0, `rank_err` = 0, `req_ready` = 0. After deassert with `i_enable` = 1 -> `req_ready` = 1.
- **MRW:** NUM_RANK = 2, MRW with mr = 8, op = 8'h98, rank = 0 -> first half `dfi_address` = 14'h0105 with `dfi_cs_n` = 2'b10. Second half 14'h0098 with 2'b11. Then 14'h0000 with 2'b11.
- **WRITE:** NUM_RANK = 2, WRITE with a1 = 9'h1FF, a2 = 14'h0000, bl_default = 1, rank = 1 -> 14'h3FED with `dfi_cs_n` = 2'b01, then 14'h0020 with 2'b11.
- **Back-to-back with gap:** GAP_CYCLES = 3, two requests with `req_valid` held high -> second first half appears exactly 6 cycles after the first first half, with 4 deselect cycles between.
- **Enable stall and reset mid-command:**
  - Drop `i_enable` for 2 cycles while in CMD_1ST -> first half held 3 cycles, then the second half.
  - Assert `i_reset` during CMD_2ND -> outputs return to deselect immediately.
- **Out-of-range rank:** NUM_RANK = 3, rank = 3 -> `dfi_cs_n` = 3'b111 in both halves. `rank_err` is high for exactly the first-half cycle, and the sequence and gap still complete.
